ps2_key_receiver: RTL and testbench
===================================

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter C_filter_len, default 8: consecutive identical ps2clk samples needed to change the filtered clock level.
REQ-002 SHALL have parameter C_timeout, default 2500: clk cycles (100 us at 25 MHz) without a filtered falling edge before a partial frame is aborted.
REQ-003 SHALL have port clk, input, 1: single system clock, same as the galaksija core clock.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2clk, input, 1: PS/2 clock line (externally pulled up, asynchronous).
REQ-006 SHALL have port ps2data, input, 1: PS/2 data line (externally pulled up, asynchronous).
REQ-007 SHALL have port rx_data, output, 8: last correctly received byte.
REQ-008 SHALL have port rx_valid, output, 1: one-cycle pulse per correctly received byte.
REQ-009 SHALL have port parity_err, output, 1: one-cycle pulse on odd-parity failure.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on bad start, bad stop or timeout.
REQ-011 SHALL have port key_code, output, 8: scan code of the last completed key event.
REQ-012 SHALL have port key_extended, output, 1: last key event was E0-prefixed.
REQ-013 SHALL have port key_release, output, 1: last key event was F0-prefixed (break).
REQ-014 SHALL have port key_strobe, output, 1: one-cycle pulse when key_code/key_extended/key_release update.

Function
REQ-015 SHALL pass ps2clk and ps2data each through a 2-flop synchronizer before any other use.
REQ-016 SHALL hold a filtered clock (reset 1) that changes only after C_filter_len consecutive synchronized samples of the opposite level.
REQ-017 SHALL detect a falling edge as a filtered-clock 1->0 transition and sample synchronized ps2data in that same cycle.
REQ-018 SHALL implement FSM states IDLE, DATA, PARITY, STOP; the reset state SHALL be IDLE.
REQ-019 In IDLE, a falling edge with data 0 SHALL go to DATA with the bit counter at 0; with data 1, it SHALL stay in IDLE and pulse frame_err.
REQ-020 In DATA, each falling edge SHALL shift in one bit, LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-021 In PARITY, the falling edge SHALL latch the parity bit and go to STOP.
REQ-022 In STOP, the falling edge SHALL always return the FSM to IDLE.
REQ-023 In STOP, a stop bit of 0 SHALL pulse frame_err.
REQ-024 In STOP, with stop bit 1 and failed odd parity (XOR of the 8 data bits and the parity bit equal to 0), parity_err SHALL pulse.
REQ-025 In STOP, with stop bit 1 and good parity, rx_data SHALL update and rx_valid SHALL pulse.
REQ-026 rx_valid, parity_err and frame_err SHALL assert on the clk edge after the edge-detect cycle, for exactly one cycle; they SHALL be mutually exclusive.
REQ-027 Outside IDLE, a timeout counter SHALL count the cycles since the last falling edge.
REQ-028 When the timeout counter reaches C_timeout, the FSM SHALL return to IDLE, discard partial bits and pulse frame_err.
REQ-029 The timeout counter SHALL be held at 0 in IDLE.
REQ-030 Prefix tracking: a valid byte E0 SHALL set a pending_ext flag; a valid byte F0 SHALL set a pending_rel flag; neither byte SHALL strobe.
REQ-031 Any other valid byte SHALL load key_code, load key_extended=pending_ext and key_release=pending_rel, and pulse key_strobe in the same cycle as rx_valid.
REQ-032 The cycle after a key_strobe, pending_ext and pending_rel SHALL both be 0.
REQ-033 parity_err or frame_err SHALL clear pending_ext and pending_rel; key outputs SHALL be unchanged.
REQ-034 rx_data, key_code, key_extended and key_release SHALL hold their value between updates.
REQ-035 The block is receive-only and SHALL never drive ps2clk or ps2data.

Reset
REQ-036 reset_n low SHALL asynchronously force: FSM IDLE, shift register, bit counter and timeout counter 0, synchronizers and filtered clock 1.
REQ-037 reset_n low SHALL asynchronously force: rx_data 0, key_code 0, all pulses 0, key_extended/key_release/pending flags 0.
REQ-038 Reset asserted mid-frame SHALL discard the frame; the first frame after release SHALL be received correctly.

Verification
REQ-039 Frame 0x1C, parity 0, stop 1, 20 us bit period -> rx_data=0x1C, exactly one rx_valid and one key_strobe, key_code=0x1C, ext=0, rel=0.
REQ-040 Bytes E0, F0, 75 -> three rx_valid pulses, one key_strobe, key_code=0x75, key_extended=1, key_release=1; a following 0x1C gives ext=0, rel=0.
REQ-041 Frame 0x1C with parity bit 1 -> one parity_err, no rx_valid, rx_data unchanged; an F0 before it does not affect the next good key.
REQ-042 Start plus 4 data bits then idle -> frame_err exactly C_timeout cycles after the last edge; the next full frame 0x29 is received correctly.
REQ-043 ps2clk low glitch of C_filter_len-1 cycles in IDLE and mid-frame -> no state change, no pulses; the frame still decodes correctly.
REQ-044 reset_n pulsed low after the 5th data bit -> all outputs 0 immediately; the next frame 0x5A gives rx_data=0x5A.

Source files
------------

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and tracks E0/F0 prefixes.
module ps2_key_receiver #(
  parameter int C_filter_len = 8,
  parameter int C_timeout    = 2500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       key_strobe,
  output logic [1:0] dbg_state
);

  localparam int FW = (C_filter_len > 1) ? $clog2(C_filter_len + 1) : 1;
  localparam int TW = $clog2(C_timeout + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(C_filter_len - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(C_timeout);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic            data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic            filt_q, filt_d;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            parity_bit_q, parity_bit_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            key_ext_q, key_ext_d;
  logic            key_rel_q, key_rel_d;
  logic            key_strobe_q, key_strobe_d;
  logic            pend_ext_q, pend_ext_d;
  logic            pend_rel_q, pend_rel_d;
  logic            fall;

  always_comb begin
    clk_s1_d     = ps2clk;
    clk_s2_d     = clk_s1_q;
    data_s1_d    = ps2data;
    data_s2_d    = data_s1_q;
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    parity_bit_d = parity_bit_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_rel_d    = key_rel_q;
    key_strobe_d = 1'b0;
    pend_ext_d   = pend_ext_q;
    pend_rel_d   = pend_rel_q;

    // Filtered clock flips only after C_filter_len consecutive opposite samples.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) filt_d = clk_s2_q;
      else                         filt_cnt_d = filt_cnt_q + FW'(1);
    end
    fall = filt_q & ~filt_d;

    case (state_q)
      IDLE: if (fall) begin
        if (!data_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_d = {data_s2_q, shift_q[7:1]};
        if (bit_cnt_q == 3'd7) state_d = PARITY;
        else                   bit_cnt_d = bit_cnt_q + 3'd1;
      end
      PARITY: if (fall) begin
        parity_bit_d = data_s2_q;
        state_d      = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (!data_s2_q)                       frame_err_d  = 1'b1;
        else if (~^{shift_q, parity_bit_q})   parity_err_d = 1'b1;
        else begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned once the line has been quiet too long.
    if (state_q != IDLE && !fall && to_cnt_q == TO_LIMIT) begin
      state_d     = IDLE;
      shift_d     = 8'h00;
      bit_cnt_d   = 3'd0;
      frame_err_d = 1'b1;
    end

    to_cnt_d = '0;
    if (state_d != IDLE) to_cnt_d = fall ? TW'(1) : to_cnt_q + TW'(1);

    if (rx_valid_d) begin
      if (shift_q == 8'hE0)      pend_ext_d = 1'b1;
      else if (shift_q == 8'hF0) pend_rel_d = 1'b1;
      else begin
        key_code_d   = shift_q;
        key_ext_d    = pend_ext_q;
        key_rel_d    = pend_rel_q;
        key_strobe_d = 1'b1;
        pend_ext_d   = 1'b0;
        pend_rel_d   = 1'b0;
      end
    end
    if (parity_err_d || frame_err_d) begin
      pend_ext_d = 1'b0;
      pend_rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      data_s1_q    <= 1'b1;
      data_s2_q    <= 1'b1;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      parity_bit_q <= 1'b0;
      to_cnt_q     <= '0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_rel_q    <= 1'b0;
      key_strobe_q <= 1'b0;
      pend_ext_q   <= 1'b0;
      pend_rel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      data_s1_q    <= data_s1_d;
      data_s2_q    <= data_s2_d;
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      parity_bit_q <= parity_bit_d;
      to_cnt_q     <= to_cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_rel_q    <= key_rel_d;
      key_strobe_q <= key_strobe_d;
      pend_ext_q   <= pend_ext_d;
      pend_rel_q   <= pend_rel_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign key_code     = key_code_q;
  assign key_extended = key_ext_q;
  assign key_release  = key_rel_q;
  assign key_strobe   = key_strobe_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: drives PS/2 frames, scoreboards received bytes and
// key events, and checks pulse timing, error handling, filtering and reset.
module tb_ps2_key_receiver;

  localparam int L  = 8;    // filter length
  localparam int TO = 300;  // timeout in clk cycles
  localparam int H  = 40;   // PS/2 clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] rx_data, key_code;
  logic       rx_valid, parity_err, frame_err;
  logic       key_extended, key_release, key_strobe;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int n_rx = 0, n_par = 0, n_frm = 0, n_key = 0;

  logic [7:0] exp_q[$];
  logic [9:0] key_exp_q[$];
  logic [7:0] e_rx;
  logic [9:0] e_key;
  bit         m_ext = 1'b0, m_rel = 1'b0;

  always #5 clk = ~clk;

  ps2_key_receiver #(.C_filter_len(L), .C_timeout(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2clk(ps2clk), .ps2data(ps2data),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .key_code(key_code), .key_extended(key_extended),
    .key_release(key_release), .key_strobe(key_strobe), .dbg_state(dbg_state)
  );

  // Scoreboard: outputs are sampled on the falling clk edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid || parity_err || frame_err) begin
        vectors++;
        if (int'(rx_valid) + int'(parity_err) + int'(frame_err) != 1) begin
          miscompares++;
          $display("FAIL pulse_exclusive: valid=%0b par=%0b frm=%0b, need exactly one", rx_valid, parity_err, frame_err);
        end
      end
      if (parity_err) n_par++;
      if (frame_err) n_frm++;
      if (rx_valid) begin
        n_rx++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rx_unexpected: got %02h, none expected", rx_data);
        end else begin
          e_rx = exp_q.pop_front();
          if (rx_data !== e_rx) begin
            miscompares++;
            $display("FAIL rx_data: got %02h, expected %02h", rx_data, e_rx);
          end
        end
      end
      if (key_strobe) begin
        n_key++;
        vectors++;
        if (!rx_valid) begin
          miscompares++;
          $display("FAIL key_strobe_align: key_strobe without rx_valid");
        end
        if (key_exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL key_unexpected: got %03h, none expected", {key_release, key_extended, key_code});
        end else begin
          e_key = key_exp_q.pop_front();
          if ({key_release, key_extended, key_code} !== e_key) begin
            miscompares++;
            $display("FAIL key_event: got rel/ext/code %03h, expected %03h", {key_release, key_extended, key_code}, e_key);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit: data set, clock high phase (optionally with a short low glitch), clock low phase.
  task automatic send_bit(input logic b, input bit glitch, output int lat);
    ps2data = b;
    if (glitch) begin
      tick_n(15);
      ps2clk = 1'b0;
      tick_n(L - 1);
      ps2clk = 1'b1;
      tick_n(H - 15 - (L - 1));
    end else begin
      tick_n(H);
    end
    ps2clk = 1'b0;
    lat = 0;
    for (int i = 1; i <= H; i++) begin
      tick_n(1);
      if (lat == 0 && (rx_valid || parity_err || frame_err)) lat = i;
    end
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                            input bit glitch, output int lat);
    logic [10:0] bits;
    logic        par;
    int          l;
    par  = ~(^d) ^ bad_par;
    bits = {stop, par, d, 1'b0};
    if (stop && !bad_par) begin
      exp_q.push_back(d);
      if (d == 8'hE0) m_ext = 1'b1;
      else if (d == 8'hF0) m_rel = 1'b1;
      else begin
        key_exp_q.push_back({m_rel, m_ext, d});
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end else begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
    l = 0;
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch, l);
    lat = l;
    tick_n(H);
  endtask

  task automatic test_reset();
    tick_n(3);
    vectors++;
    if ({rx_data, key_code, rx_valid, parity_err, frame_err, key_extended, key_release, key_strobe} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %06h, expected 000000",
               {rx_data, key_code, rx_valid, parity_err, frame_err, key_extended, key_release, key_strobe});
    end
    vectors++;
    if (dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d, expected 0", dbg_state);
    end
    reset_n = 1'b1;
    tick_n(5);
  endtask

  task automatic test_single();
    int r0, k0, lat;
    r0 = n_rx; k0 = n_key;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, lat);
    vectors++;
    if (n_rx - r0 != 1 || n_key - k0 != 1) begin
      miscompares++;
      $display("FAIL single_counts: rx %0d key %0d, expected 1 and 1", n_rx - r0, n_key - k0);
    end
    vectors++;
    if (lat != L + 2) begin
      miscompares++;
      $display("FAIL single_latency: got %0d cycles, expected %0d", lat, L + 2);
    end
    vectors++;
    if ({rx_data, key_release, key_extended, key_code} !== {8'h1C, 2'b00, 8'h1C}) begin
      miscompares++;
      $display("FAIL single_hold: got %02h %0b%0b %02h, expected 1c 00 1c", rx_data, key_release, key_extended, key_code);
    end
  endtask

  task automatic test_prefix();
    int r0, k0, lat;
    r0 = n_rx; k0 = n_key;
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, lat);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, lat);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0, lat);
    vectors++;
    if (n_rx - r0 != 3 || n_key - k0 != 1) begin
      miscompares++;
      $display("FAIL prefix_counts: rx %0d key %0d, expected 3 and 1", n_rx - r0, n_key - k0);
    end
    vectors++;
    if ({key_release, key_extended, key_code} !== {2'b11, 8'h75}) begin
      miscompares++;
      $display("FAIL prefix_key: got %0b%0b %02h, expected 11 75", key_release, key_extended, key_code);
    end
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, lat);
    vectors++;
    if ({key_release, key_extended, key_code} !== {2'b00, 8'h1C}) begin
      miscompares++;
      $display("FAIL prefix_cleared: got %0b%0b %02h, expected 00 1c", key_release, key_extended, key_code);
    end
  endtask

  task automatic test_parity();
    int r0, p0, lat;
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, lat);
    r0 = n_rx; p0 = n_par;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, lat);
    vectors++;
    if (n_par - p0 != 1 || n_rx - r0 != 0) begin
      miscompares++;
      $display("FAIL parity_counts: par %0d rx %0d, expected 1 and 0", n_par - p0, n_rx - r0);
    end
    vectors++;
    if ({rx_data, key_release, key_extended, key_code} !== {8'hF0, 2'b00, 8'h1C}) begin
      miscompares++;
      $display("FAIL parity_hold: got %02h %0b%0b %02h, expected f0 00 1c", rx_data, key_release, key_extended, key_code);
    end
    send_frame(8'h16, 1'b0, 1'b1, 1'b0, lat);
    vectors++;
    if ({key_release, key_extended, key_code} !== {2'b00, 8'h16}) begin
      miscompares++;
      $display("FAIL parity_next_key: got %0b%0b %02h, expected 00 16", key_release, key_extended, key_code);
    end
  endtask

  task automatic test_timeout();
    int f0, r0, lat, found;
    logic [7:0] d;
    d = 8'hA5;
    f0 = n_frm; r0 = n_rx;
    m_ext = 1'b0; m_rel = 1'b0;
    send_bit(1'b0, 1'b0, lat);
    for (int i = 0; i < 3; i++) send_bit(d[i], 1'b0, lat);
    ps2data = d[3];
    tick_n(H);
    ps2clk = 1'b0;
    found = 0;
    for (int i = 1; i <= TO + L + 2 + H; i++) begin
      tick_n(1);
      if (i == H) ps2clk = 1'b1;
      if (found == 0 && frame_err) found = i;
    end
    ps2clk = 1'b1;
    vectors++;
    if (found != TO + L + 2) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles, expected %0d", found, TO + L + 2);
    end
    vectors++;
    if (n_frm - f0 != 1 || n_rx - r0 != 0) begin
      miscompares++;
      $display("FAIL timeout_counts: frm %0d rx %0d, expected 1 and 0", n_frm - f0, n_rx - r0);
    end
    tick_n(H);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, lat);
    vectors++;
    if ({rx_data, key_code} !== {8'h29, 8'h29}) begin
      miscompares++;
      $display("FAIL timeout_recover: got %02h %02h, expected 29 29", rx_data, key_code);
    end
  endtask

  task automatic test_glitch();
    int tot0, lat;
    tot0 = n_rx + n_par + n_frm;
    ps2clk = 1'b0;
    tick_n(L - 1);
    ps2clk = 1'b1;
    tick_n(H);
    vectors++;
    if (n_rx + n_par + n_frm != tot0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL glitch_idle: pulses %0d state %0d, expected 0 and 0", n_rx + n_par + n_frm - tot0, dbg_state);
    end
    send_frame(8'h3A, 1'b0, 1'b1, 1'b1, lat);
    vectors++;
    if (n_rx + n_par + n_frm != tot0 + 1 || rx_data !== 8'h3A || lat != L + 2) begin
      miscompares++;
      $display("FAIL glitch_frame: pulses %0d data %02h lat %0d, expected 1 3a %0d",
               n_rx + n_par + n_frm - tot0, rx_data, lat, L + 2);
    end
  endtask

  task automatic test_reset_mid();
    int lat, e0;
    logic [7:0] d;
    d = 8'h33;
    send_bit(1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) send_bit(d[i], 1'b0, lat);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({rx_data, key_code, rx_valid, parity_err, frame_err, key_extended, key_release, key_strobe, dbg_state} !== 24'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %06h, expected 000000",
               {rx_data, key_code, rx_valid, parity_err, frame_err, key_extended, key_release, key_strobe, dbg_state});
    end
    m_ext = 1'b0; m_rel = 1'b0;
    ps2data = 1'b1;
    tick_n(3);
    reset_n = 1'b1;
    tick_n(5);
    e0 = n_par + n_frm;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, lat);
    vectors++;
    if ({rx_data, key_release, key_extended, key_code} !== {8'h5A, 2'b00, 8'h5A} || n_par + n_frm != e0) begin
      miscompares++;
      $display("FAIL midreset_recover: got %02h %0b%0b %02h errs %0d, expected 5a 00 5a 0",
               rx_data, key_release, key_extended, key_code, n_par + n_frm - e0);
    end
  endtask

  task automatic test_back_to_back();
    int r0, lat;
    logic [7:0] d;
    r0 = n_rx;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b0, 1'b1, 1'b0, lat);
    end
    vectors++;
    if (n_rx - r0 != 6 || exp_q.size() != 0 || key_exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: rx %0d left %0d/%0d, expected 6 0/0", n_rx - r0, exp_q.size(), key_exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
